// File: rtl/mem_req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter_pkg
//   Shared types and constants for the memory request arbiter: FSM state
//   encoding, owner IDs, request-vector bit positions, legal transfer
//   lengths and the default bus widths.
// ---------------------------------------------------------------------------
package mem_req_arbiter_pkg;

  // Default bus widths for the byte-wide memory controller interface.
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2,
    OWN_ST   = 2'd3
  } owner_e;

  // Bit positions inside the request / grant vectors.
  localparam int unsigned REQ_IF = 0;
  localparam int unsigned REQ_LD = 1;
  localparam int unsigned REQ_ST = 2;

  // Legal transfer lengths in bytes.
  localparam logic [2:0] LEN_1 = 3'd1;
  localparam logic [2:0] LEN_2 = 3'd2;
  localparam logic [2:0] LEN_4 = 3'd4;

  function automatic logic len_legal(input logic [2:0] len);
    return (len == LEN_1) || (len == LEN_2) || (len == LEN_4);
  endfunction

  // Anything other than 1/2/4 is treated as a full word.
  function automatic logic [2:0] len_fix(input logic [2:0] len);
    return len_legal(len) ? len : LEN_4;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
//   Combinational grant selection for the memory request arbiter.
//   Priority ST > LD > IF, except that a starving IF wins outright.
//   A flush removes IF and LD from the contest for that cycle.
// Ports:
//   req_vec  in  3  requests, indexed by REQ_IF / REQ_LD / REQ_ST
//   flush_in in  1  pipeline flush
//   starve   in  1  IF has waited STARVE_LIMIT data grants
//   grant    out 3  one-hot grant (all zero when nothing wins)
// ---------------------------------------------------------------------------
module arb_pick
  import mem_req_arbiter_pkg::*;
(
  input  logic [2:0] req_vec,
  input  logic       flush_in,
  input  logic       starve,
  output logic [2:0] grant
);

  always_comb begin
    grant = '0;
    if (starve && req_vec[REQ_IF] && !flush_in) begin
      grant[REQ_IF] = 1'b1;
    end else if (req_vec[REQ_ST]) begin
      grant[REQ_ST] = 1'b1;
    end else if (!flush_in) begin
      if (req_vec[REQ_LD]) begin
        grant[REQ_LD] = 1'b1;
      end else if (req_vec[REQ_IF]) begin
        grant[REQ_IF] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter
//   Shares the single request port of the byte-wide memory controller
//   between instruction fetch (IF), load buffer (LD) and store commit (ST).
//   One request is latched at a time, driven to the controller until its
//   done pulse, then answered to the owner with a one-cycle done pulse.
//   A pipeline flush cancels IF/LD responses but never a store.
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (global enable), flush_in
//   if_req/if_addr      -> if_done/if_data    fetch (always 4 bytes)
//   ld_req/ld_addr/ld_len -> ld_done/ld_data  load (zero-extended data)
//   st_req/st_addr/st_data/st_len -> st_done  store
//   mc_get/mc_wr/mc_addr/mc_data/mc_len -> controller, mc_done/mc_out back
//   busy                                      high whenever not IDLE
// ---------------------------------------------------------------------------
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_len,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_data,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [2:0]        st_len,
  output logic              st_done,
  output logic              mc_get,
  output logic              mc_wr,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [DATA_W-1:0] mc_data,
  output logic [2:0]        mc_len,
  input  logic              mc_done,
  input  logic [DATA_W-1:0] mc_out,
  output logic              busy
);

  localparam int unsigned      CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e       state;
  owner_e           owner;
  logic             cancel;
  logic [CNT_W-1:0] starve_cnt;

  logic [2:0] req_vec;
  logic [2:0] grant;
  logic       starve;
  logic       flush_kill;

  always_comb begin
    req_vec         = '0;
    req_vec[REQ_IF] = if_req;
    req_vec[REQ_LD] = ld_req;
    req_vec[REQ_ST] = st_req;
  end

  assign starve = (starve_cnt == STARVE_MAX);

  // A flush only matters for transactions whose response can be discarded.
  assign flush_kill = flush_in && ((owner == OWN_IF) || (owner == OWN_LD));

  arb_pick u_pick (
    .req_vec  (req_vec),
    .flush_in (flush_in),
    .starve   (starve),
    .grant    (grant)
  );

  function automatic logic [DATA_W-1:0] len_mask(input logic [2:0] len);
    logic [DATA_W-1:0] m;
    m = '1;
    if (len == LEN_1) begin
      m = DATA_W'(8'hFF);
    end else if (len == LEN_2) begin
      m = DATA_W'(16'hFFFF);
    end
    return m;
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      cancel     <= 1'b0;
      starve_cnt <= '0;
      busy       <= 1'b0;
      mc_get     <= 1'b0;
      mc_wr      <= 1'b0;
      mc_addr    <= '0;
      mc_data    <= '0;
      mc_len     <= '0;
      if_done    <= 1'b0;
      if_data    <= '0;
      ld_done    <= 1'b0;
      ld_data    <= '0;
      st_done    <= 1'b0;
    end else if (rdy_in) begin
      case (state)
        IDLE: begin
          if (grant[REQ_IF] || !if_req) begin
            starve_cnt <= '0;
          end else if ((grant[REQ_LD] || grant[REQ_ST]) && !starve) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end

          if (grant[REQ_ST]) begin
            owner   <= OWN_ST;
            mc_wr   <= 1'b1;
            mc_addr <= st_addr;
            mc_data <= st_data;
            mc_len  <= len_fix(st_len);
          end else if (grant[REQ_LD]) begin
            owner   <= OWN_LD;
            mc_wr   <= 1'b0;
            mc_addr <= ld_addr;
            mc_data <= '0;
            mc_len  <= len_fix(ld_len);
          end else if (grant[REQ_IF]) begin
            owner   <= OWN_IF;
            mc_wr   <= 1'b0;
            mc_addr <= if_addr;
            mc_data <= '0;
            mc_len  <= LEN_4;
          end

          // mc_get rises together with the ISSUE state so the request is
          // visible on the controller port in the cycle after the grant.
          if (|grant) begin
            mc_get <= 1'b1;
            busy   <= 1'b1;
            cancel <= 1'b0;
            state  <= ISSUE;
          end
        end

        ISSUE: begin
          if (flush_kill) begin
            cancel <= 1'b1;
          end
          state <= WAIT;
        end

        WAIT: begin
          if (flush_kill) begin
            cancel <= 1'b1;
          end
          if (mc_done) begin
            mc_get  <= 1'b0;
            mc_wr   <= 1'b0;
            mc_addr <= '0;
            mc_data <= '0;
            mc_len  <= '0;
            state   <= RESP;
            // mc_out is captured straight into the owner's data register so
            // the done pulse and its data appear together in RESP. A flush
            // in this same cycle already counts as a cancel.
            if (!cancel && !flush_kill) begin
              case (owner)
                OWN_IF: begin
                  if_done <= 1'b1;
                  if_data <= mc_out;
                end
                OWN_LD: begin
                  ld_done <= 1'b1;
                  ld_data <= mc_out & len_mask(mc_len);
                end
                OWN_ST: begin
                  st_done <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end

        RESP: begin
          // The response was already committed on entry; a flush arriving
          // now is absorbed by clearing cancel on the way back to IDLE.
          if_done <= 1'b0;
          if_data <= '0;
          ld_done <= 1'b0;
          ld_data <= '0;
          st_done <= 1'b0;
          cancel  <= 1'b0;
          owner   <= OWN_NONE;
          busy    <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  a_ld_len: assert property (@(posedge clk_in) disable iff (rst_in)
    (rdy_in && (state == IDLE) && grant[REQ_LD]) |-> len_legal(ld_len));

  a_st_len: assert property (@(posedge clk_in) disable iff (rst_in)
    (rdy_in && (state == IDLE) && grant[REQ_ST]) |-> len_legal(st_len));

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic        if_req;  logic [31:0] if_addr;
  logic        if_done; logic [31:0] if_data;
  logic        ld_req;  logic [31:0] ld_addr; logic [2:0] ld_len;
  logic        ld_done; logic [31:0] ld_data;
  logic        st_req;  logic [31:0] st_addr; logic [31:0] st_data; logic [2:0] st_len;
  logic        st_done;
  logic        mc_get, mc_wr; logic [31:0] mc_addr, mc_data; logic [2:0] mc_len;
  logic        mc_done; logic [31:0] mc_out;
  logic        busy;

  always #5 clk_in = ~clk_in;

  mem_req_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_done(ld_done), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_len(st_len), .st_done(st_done),
    .mc_get(mc_get), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_data(mc_data), .mc_len(mc_len),
    .mc_done(mc_done), .mc_out(mc_out), .busy(busy)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // stimulus control
  bit          auto_mode = 0;
  bit          rearm = 0;
  bit          ctl_fixed = 1;
  int unsigned ctl_delay = 3;
  logic [31:0] ctl_data = 32'h0;
  int          ctl_st = 0;
  int          ctl_cnt = 0;

  // transaction-level reference model (owner: 0 none, 1 IF, 2 LD, 3 ST)
  bit          m_active = 0, m_issued = 0, m_resp = 0, m_cancel = 0, m_wr = 0;
  int          m_owner = 0, m_len = 0, m_starve = 0;
  logic [31:0] m_addr = 0, m_data = 0, m_rdata = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] pick_len();
    case ($urandom_range(0, 2))
      0:       return 3'd1;
      1:       return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  task automatic new_if();
    if_req = 1'b1; if_addr = $urandom & 32'h0000_0FFC;
  endtask
  task automatic new_ld();
    ld_req = 1'b1; ld_addr = $urandom & 32'h0000_0FFF; ld_len = pick_len();
  endtask
  task automatic new_st();
    st_req = 1'b1; st_addr = $urandom & 32'h0000_0FFF; st_data = $urandom; st_len = pick_len();
  endtask

  // Requesters react to completions; controller answers mc_get after a delay.
  task automatic gen_inputs();
    if (if_done) if_req = 1'b0;
    if (ld_done) begin if (rearm) new_ld(); else ld_req = 1'b0; end
    if (st_done) begin if (rearm) new_st(); else st_req = 1'b0; end
    if (auto_mode) begin
      rst_in   = ($urandom_range(0, 99) < 1);
      rdy_in   = ($urandom_range(0, 99) < 85);
      flush_in = ($urandom_range(0, 99) < 6);
      if (!if_req && $urandom_range(0, 3) == 0) new_if();
      if (!ld_req && $urandom_range(0, 3) == 0) new_ld();
      if (!st_req && $urandom_range(0, 4) == 0) new_st();
    end
    mc_done = 1'b0;
    mc_out  = $urandom;
    if (rst_in) begin
      ctl_st = 0;
    end else begin
      if (ctl_st == 3 && !mc_get) ctl_st = 0;
      if (ctl_st == 0 && mc_get) ctl_st = 1;
      if (ctl_st == 1 && rdy_in) begin
        ctl_st  = 2;
        ctl_cnt = ctl_fixed ? int'(ctl_delay) - 1 : int'($urandom_range(0, 3));
      end else if (ctl_st == 2 && rdy_in) begin
        if (ctl_cnt == 0) begin
          mc_done = 1'b1;
          if (ctl_fixed) mc_out = ctl_data;
          ctl_st = 3;
        end else begin
          ctl_cnt--;
        end
      end
    end
  endtask

  // Advance the model across the coming clock edge using the driven inputs.
  task automatic model_step();
    int w;
    bit kill;
    w = 0;
    kill = flush_in && (m_owner == 1 || m_owner == 2);
    if (rst_in) begin
      m_active = 0; m_issued = 0; m_resp = 0; m_cancel = 0; m_owner = 0; m_starve = 0;
    end else if (rdy_in) begin
      if (!m_active) begin
        if (m_starve == int'(LIMIT) && if_req && !flush_in) w = 1;
        else if (st_req)                                  w = 3;
        else if (!flush_in && ld_req)                     w = 2;
        else if (!flush_in && if_req)                     w = 1;
        if (!if_req || w == 1)  m_starve = 0;
        else if (w >= 2)        m_starve = (m_starve < int'(LIMIT)) ? m_starve + 1 : int'(LIMIT);
        if (w != 0) begin
          m_active = 1; m_issued = 0; m_resp = 0; m_cancel = 0; m_owner = w;
          case (w)
            1: begin m_addr = if_addr; m_data = 0; m_len = 4; m_wr = 0; end
            2: begin m_addr = ld_addr; m_data = 0; m_len = int'(ld_len); m_wr = 0; end
            default: begin m_addr = st_addr; m_data = st_data; m_len = int'(st_len); m_wr = 1; end
          endcase
        end
      end else if (!m_issued) begin
        m_issued = 1;
        if (kill) m_cancel = 1;
      end else if (!m_resp) begin
        if (kill) m_cancel = 1;
        if (mc_done) begin m_resp = 1; m_rdata = mc_out; end
      end else begin
        m_active = 0; m_owner = 0;
      end
    end
  endtask

  task automatic check_outputs();
    bit get, dn;
    logic [63:0] mk;
    get = m_active && !m_resp;
    dn  = m_active && m_resp && !m_cancel;
    mk  = (64'd1 << (8 * m_len)) - 64'd1;
    chk("busy",    64'(busy),    64'(m_active));
    chk("mc_get",  64'(mc_get),  64'(get));
    chk("mc_wr",   64'(mc_wr),   64'(get && m_wr));
    chk("mc_addr", 64'(mc_addr), get ? 64'(m_addr) : 64'd0);
    chk("mc_data", 64'(mc_data), get ? 64'(m_data) : 64'd0);
    chk("mc_len",  64'(mc_len),  get ? 64'(m_len) : 64'd0);
    chk("if_done", 64'(if_done), 64'(dn && m_owner == 1));
    chk("if_data", 64'(if_data), (dn && m_owner == 1) ? 64'(m_rdata) : 64'd0);
    chk("ld_done", 64'(ld_done), 64'(dn && m_owner == 2));
    chk("ld_data", 64'(ld_data), (dn && m_owner == 2) ? (64'(m_rdata) & mk) : 64'd0);
    chk("st_done", 64'(st_done), 64'(dn && m_owner == 3));
  endtask

  task automatic tick();
    gen_inputs();
    model_step();
    @(negedge clk_in);
    check_outputs();
  endtask

  task automatic drain();
    for (int i = 0; i < 150; i++) begin
      if (!busy && !if_req && !ld_req && !st_req) break;
      tick();
    end
    chk("drain_idle", {60'd0, busy, if_req, ld_req, st_req}, 64'd0);
  endtask

  initial begin
    logic [31:0] g_addr, g_data, ldd, cap_addr;
    logic [2:0]  g_len;
    logic        g_wr, prev_get;
    int          first_get, done_at, got, dones, grants, if_won, ld_seen, cap;
    logic [31:0] q[$];

    rst_in = 1; rdy_in = 1; flush_in = 0;
    if_req = 0; if_addr = 0; ld_req = 0; ld_addr = 0; ld_len = 3'd4;
    st_req = 0; st_addr = 0; st_data = 0; st_len = 3'd4;
    mc_done = 0; mc_out = 0;

    // reset
    tick(); tick();
    rst_in = 0;
    chk("reset_outs", {busy, mc_get, mc_wr, if_done, ld_done, st_done, mc_addr, mc_len}, 64'd0);

    // single fetch, controller answers 3 cycles after mc_get
    ctl_delay = 3; ctl_data = 32'hDEADBEEF;
    if_addr = 32'h100; if_req = 1;
    first_get = -1; done_at = -1; got = 0; g_addr = 0; g_len = 0; g_wr = 1; g_data = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      tick();
      if (mc_get && first_get < 0) begin first_get = i; g_addr = mc_addr; g_len = mc_len; g_wr = mc_wr; end
      if (if_done) begin got = 1; done_at = i; g_data = if_data; end
    end
    chk("if_seen", 64'(got), 64'd1);
    chk("if_mc_addr", 64'(g_addr), 64'h100);
    chk("if_mc_len", 64'(g_len), 64'd4);
    chk("if_mc_wr", 64'(g_wr), 64'd0);
    chk("if_data_lit", 64'(g_data), 64'hDEADBEEF);
    chk("if_latency", 64'(done_at - first_get), 64'd4);
    tick();
    chk("if_busy_after", 64'(busy), 64'd0);

    // priority ST > LD > IF, halfword load masking
    ctl_delay = 1; ctl_data = 32'h9988BBAA;
    st_addr = 32'h200; st_data = 32'h11223344; st_len = 3'd4; st_req = 1;
    ld_addr = 32'h300; ld_len = 3'd2; ld_req = 1;
    if_addr = 32'h100; if_req = 1;
    prev_get = 0; dones = 0; ldd = 0;
    for (int i = 0; i < 80 && dones < 3; i++) begin
      tick();
      if (mc_get && !prev_get) q.push_back(mc_addr);
      prev_get = mc_get;
      if (ld_done) ldd = ld_data;
      dones += int'(if_done) + int'(ld_done) + int'(st_done);
    end
    while (q.size() < 3) q.push_back(32'hFFFF_FFFF);
    chk("prio_first", 64'(q[0]), 64'h200);
    chk("prio_second", 64'(q[1]), 64'h300);
    chk("prio_third", 64'(q[2]), 64'h100);
    chk("ld_data_lit", 64'(ldd), 64'h0000BBAA);
    drain();

    // starvation: ST/LD re-request continuously while IF waits
    ctl_delay = 2; rearm = 1;
    if_addr = 32'h4000; if_req = 1; new_ld(); new_st();
    prev_get = 0; grants = 0; if_won = 0;
    for (int i = 0; i < 200 && if_won == 0; i++) begin
      tick();
      if (mc_get && !prev_get) begin
        if (mc_addr == 32'h4000 && !mc_wr && mc_len == 3'd4) if_won = 1;
        else grants++;
      end
      prev_get = mc_get;
    end
    chk("starve_if_won", 64'(if_won), 64'd1);
    chk("starve_grants", 64'(grants), 64'(LIMIT));
    rearm = 0;
    drain();

    // flush during a load's WAIT: no ld_done, pending store wins next
    ctl_delay = 3;
    ld_addr = 32'h500; ld_len = 3'd4; ld_req = 1;
    tick(); tick();
    flush_in = 1;
    st_addr = 32'h600; st_data = 32'hA5A5A5A5; st_len = 3'd1; st_req = 1;
    tick();
    flush_in = 0;
    prev_get = mc_get; ld_seen = 0; cap = 0; cap_addr = 0;
    for (int i = 0; i < 30 && cap == 0; i++) begin
      tick();
      if (ld_done) ld_seen++;
      if (mc_get && !prev_get) begin cap = 1; cap_addr = mc_addr; end
      prev_get = mc_get;
    end
    chk("flush_no_ld_done", 64'(ld_seen), 64'd0);
    chk("flush_next_grant", 64'(cap_addr), 64'h600);
    drain();

    // randomized traffic with rdy stalls, flushes and resets
    ctl_fixed = 0; auto_mode = 1;
    for (int i = 0; i < 3000; i++) tick();
    auto_mode = 0; rst_in = 0; rdy_in = 1; flush_in = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
